dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port data memory (1024 × 32, 1-cycle registered read, write-over-read priority) between the CPU MEM stage (port 0) and the DMA/loader engine (port 1). Grants one access per cycle with fixed priority to the CPU, a starvation guard for DMA, and a lock for atomic read-modify-write sequences. Routes each read response back to the port that issued it. Sits between the core/DMA and the memory macro; the memory's own rst is driven from the same rst.

## Interface
- ADDR_WIDTH, 10, memory word-address width
- WORD_WIDTH, 32, data width
- STARVE_LIMIT, 4, consecutive cycles port 1 may be denied before it is forced to win
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- p0_req / p1_req  in  1  access request, held until granted
- p0_we / p1_we  in  1  1 = write, 0 = read; qualified by req
- p0_lock / p1_lock  in  1  keep ownership after this access
- p0_addr / p1_addr  in  ADDR_WIDTH  word address
- p0_wdata / p1_wdata  in  WORD_WIDTH  write data
- p0_gnt / p1_gnt  out  1  access accepted this cycle (combinational)
- p0_rvalid / p1_rvalid  out  1  read data valid (registered)
- p0_rdata / p1_rdata  out  WORD_WIDTH  read data; 0 when rvalid low
- mem_write, mem_read  out  1  memory strobes (combinational from grant)
- mem_addr  out  ADDR_WIDTH; mem_wdata  out  WORD_WIDTH
- mem_rdata  in  WORD_WIDTH  memory read register

## Operation
- FSM states: ARB, LOCK0, LOCK1. Reset state ARB.
- ARB: if starve_cnt == STARVE_LIMIT and p1_req → grant p1; else p0_req → grant p0; else p1_req → grant p1; else no grant.
- starve_cnt: increments when p1_req && !p1_gnt, saturates at STARVE_LIMIT, clears on p1_gnt or !p1_req.
- Grant with lock=1 → next state LOCKn (n = granted port). LOCKn grants only port n; other port's gnt held 0, starve_cnt frozen. Port n access with lock=0 → ARB. LOCKn with pn_req low: stay locked, no grant.
- Granted port drives mem_addr/mem_wdata; mem_write = gnt && we, mem_read = gnt && !we. No grant: both strobes 0, addr/wdata 0.
- Read response: resp_valid/resp_port registered on read grant; next cycle pN_rvalid=1 for resp_port only, pN_rdata = mem_rdata.
- Writes produce no rvalid; complete at grant edge.
- Same-address ops from both ports ordered strictly by grant order (read after write in next cycle returns new data).
- Reset: all gnt, strobes, rvalid = 0, rdata = 0, starve_cnt = 0, state ARB, pending response dropped. rst mid-lock releases lock. gnt forced 0 while rst high.

## Timing
- Request to grant: 0 cycles when winning (gnt combinational from req, state, starve_cnt).
- Read grant in cycle N → rvalid + rdata in cycle N+1 exactly; back-to-back reads give one response per cycle.
- Write grant in cycle N → data visible to read granted in N+1.
- Worst-case port 1 wait with p0 saturating and no lock: STARVE_LIMIT+1 cycles. Lock has no timeout.

## Structure
- Shared defines header: WORD_WIDTH, ADDR_WIDTH, state encodings (ARB/LOCK0/LOCK1).
- One sub-module natural: dmem_resp_router (resp_valid/resp_port register and rdata demux).

## Test plan
- Reset: hold rst 2 cycles with both req high → all gnt/strobes/rvalid 0; first cycle after release p0 granted.
- Contention: both ports read every cycle, STARVE_LIMIT=4 → p0 granted 4 cycles, p1 on 5th, pattern repeats; each rvalid lands on issuing port next cycle.
- Ordering: p1 write 0xDEADBEEF to addr 0x3FF, p0 reads 0x3FF next cycle → p0_rdata=0xDEADBEEF one cycle later.
- Lock: p1 reads addr 5 with lock=1, p0 req high → p0_gnt low until p1 writes addr 5 with lock=0; p0 granted cycle after.
- Reset mid-lock: rst during LOCK0 with pending read → no rvalid after reset, state ARB, p1 grantable immediately.
- Idle: no req for 10 cycles → mem_read/mem_write 0, starve_cnt 0, no rvalid.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared widths and arbiter state encodings for the data-memory arbiter slice.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W   = 10;
  localparam int DMEM_WORD_W   = 32;
  localparam int DMEM_STARVE_N = 4;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_resp_router.sv
// Tracks which port issued the last read and steers the memory's registered
// read data back to that port one cycle after the grant.
module dmem_resp_router #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_gnt,
  input  logic                  read_port,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  p0_rvalid,
  output logic [WORD_WIDTH-1:0] p0_rdata,
  output logic                  p1_rvalid,
  output logic [WORD_WIDTH-1:0] p1_rdata
);

  logic resp_valid_d, resp_valid_q;
  logic resp_port_d, resp_port_q;

  always_comb begin
    resp_valid_d = read_gnt;
    resp_port_d  = read_gnt ? read_port : resp_port_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
    end
  end

  // Gating with rst drops a response that was in flight when reset arrived.
  always_comb begin
    p0_rvalid = resp_valid_q && !resp_port_q && !rst;
    p1_rvalid = resp_valid_q &&  resp_port_q && !rst;
    p0_rdata  = p0_rvalid ? mem_rdata : '0;
    p1_rdata  = p1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority (CPU first) arbiter for the single-port data memory, with a
// DMA starvation guard and per-port lock for read-modify-write sequences.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DMEM_ADDR_W,
  parameter int WORD_WIDTH   = DMEM_WORD_W,
  parameter int STARVE_LIMIT = DMEM_STARVE_N,
  localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic                  p0_lock,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [WORD_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [WORD_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic                  p1_lock,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [WORD_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [WORD_WIDTH-1:0] p1_rdata,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output arb_state_e            dbg_state,
  output logic [CNT_W-1:0]      dbg_starve_cnt
);

  // Handshake: pN_req (with we/lock/addr/wdata) is held stable until pN_gnt is
  // sampled high at a rising edge; the access is accepted at that edge.

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_d, state_q;
  logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;
  logic             sel_we;

  always_comb begin
    state_d = state_q;
    p0_gnt  = 1'b0;
    p1_gnt  = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (starve_cnt_q == STARVE_MAX && p1_req) p1_gnt = 1'b1;
          else if (p0_req)                          p0_gnt = 1'b1;
          else if (p1_req)                          p1_gnt = 1'b1;
          if (p0_gnt && p0_lock)      state_d = LOCK0;
          else if (p1_gnt && p1_lock) state_d = LOCK1;
        end
        LOCK0: begin
          p0_gnt = p0_req;
          if (p0_gnt && !p0_lock) state_d = ARB;
        end
        LOCK1: begin
          p1_gnt = p1_req;
          if (p1_gnt && !p1_lock) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  // The guard only counts while arbitrating; a lock owner freezes it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == ARB) begin
      if (!p1_req || p1_gnt)          starve_cnt_d = '0;
      else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    sel_we    = 1'b0;
    if (p0_gnt) begin
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      sel_we    = p0_we;
    end else if (p1_gnt) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      sel_we    = p1_we;
    end
    mem_write = (p0_gnt || p1_gnt) && sel_we;
    mem_read  = (p0_gnt || p1_gnt) && !sel_we;
  end

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt_q;

  dmem_resp_router #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_resp_router (
    .clk      (clk),
    .rst      (rst),
    .read_gnt (mem_read),
    .read_port(p1_gnt),
    .mem_rdata(mem_rdata),
    .p0_rvalid(p0_rvalid),
    .p0_rdata (p0_rdata),
    .p1_rvalid(p1_rvalid),
    .p1_rdata (p1_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x32 registered-read memory.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [9:0]  p0_addr, p1_addr, mem_addr;
  logic [31:0] p0_wdata, p1_wdata, mem_wdata, mem_rdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_write, mem_read;
  logic [31:0] p0_rdata, p1_rdata;
  arb_state_e  dbg_state;
  logic [2:0]  dbg_starve_cnt;
  logic [31:0] mem [1024];

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock and memory model: word at address a starts as 0xA5A5_0000 | a.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) mem_rdata <= '0;
    else if (mem_read) mem_rdata <= mem[mem_addr];
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_p0(input logic req, input logic we, input logic lock,
                          input logic [9:0] addr, input logic [31:0] wdata);
    p0_req = req; p0_we = we; p0_lock = lock; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic lock,
                          input logic [9:0] addr, input logic [31:0] wdata);
    p1_req = req; p1_we = we; p1_lock = lock; p1_addr = addr; p1_wdata = wdata;
  endtask

  task automatic idle_all();
    drive_p0(0, 0, 0, '0, '0);
    drive_p1(0, 0, 0, '0, '0);
  endtask

  // Inputs change 1 ns after the rising edge; checks run at the falling edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    #4;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | i;
    rst = 1'b1;
    drive_p0(1, 0, 0, 10'd1, '0);
    drive_p1(1, 0, 0, 10'd2, '0);

    // Reset held two cycles with both ports requesting.
    for (int c = 0; c < 2; c++) begin
      next_cycle(); mid();
      chk("rst_p0_gnt", p0_gnt, 0);
      chk("rst_p1_gnt", p1_gnt, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_p0_rvalid", p0_rvalid, 0);
      chk("rst_p1_rvalid", p1_rvalid, 0);
      chk("rst_state", dbg_state, ARB);
      chk("rst_starve", dbg_starve_cnt, 0);
    end

    // Contention: both ports read every cycle; expected winners p0,p0,p0,p0,p1 repeating.
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_p0(1, 0, 0, 10'(16 + k), '0);
      drive_p1(1, 0, 0, 10'(32 + k), '0);
      mid();
      chk("cont_p0_gnt", p0_gnt, (k % 5 != 4));
      chk("cont_p1_gnt", p1_gnt, (k % 5 == 4));
      chk("cont_starve", dbg_starve_cnt, k % 5);
      chk("cont_mem_read", mem_read, 1);
      chk("cont_addr", mem_addr, (k % 5 == 4) ? 32 + k : 16 + k);
      if (k > 0) begin
        if ((k - 1) % 5 == 4) begin
          chk("cont_p1_rvalid", p1_rvalid, 1);
          chk("cont_p1_rdata", p1_rdata, 32'hA5A5_0000 | (32 + k - 1));
          chk("cont_p0_rvalid_off", p0_rvalid, 0);
        end else begin
          chk("cont_p0_rvalid", p0_rvalid, 1);
          chk("cont_p0_rdata", p0_rdata, 32'hA5A5_0000 | (16 + k - 1));
          chk("cont_p1_rvalid_off", p1_rvalid, 0);
          chk("cont_p1_rdata_zero", p1_rdata, 0);
        end
      end
      next_cycle();
    end
    idle_all(); mid();
    chk("cont_last_p1_rvalid", p1_rvalid, 1);
    chk("cont_last_p1_rdata", p1_rdata, 32'hA5A5_0029);
    chk("cont_last_p0_rvalid", p0_rvalid, 0);
    next_cycle();

    // Ordering: p1 writes 0x3FF, p0 reads it the next cycle.
    drive_p1(1, 1, 0, 10'h3FF, 32'hDEAD_BEEF); mid();
    chk("ord_p1_gnt", p1_gnt, 1);
    chk("ord_mem_write", mem_write, 1);
    chk("ord_mem_read", mem_read, 0);
    chk("ord_waddr", mem_addr, 10'h3FF);
    chk("ord_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    idle_all(); drive_p0(1, 0, 0, 10'h3FF, '0); mid();
    chk("ord_p0_gnt", p0_gnt, 1);
    chk("ord_rd_strobe", mem_read, 1);
    chk("ord_no_rvalid_for_write", p1_rvalid, 0);
    next_cycle();
    idle_all(); mid();
    chk("ord_p0_rvalid", p0_rvalid, 1);
    chk("ord_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
    chk("ord_p1_rvalid", p1_rvalid, 0);
    chk("ord_idle_addr", mem_addr, 0);
    next_cycle();

    // Lock: p1 owns the memory for a read-modify-write of address 5.
    drive_p1(1, 0, 1, 10'd5, '0); mid();
    chk("lock_p1_gnt", p1_gnt, 1);
    next_cycle();
    drive_p1(0, 0, 0, '0, '0); drive_p0(1, 0, 0, 10'd6, '0); mid();
    chk("lock_state", dbg_state, LOCK1);
    chk("lock_p0_blocked", p0_gnt, 0);
    chk("lock_p1_idle_gnt", p1_gnt, 0);
    chk("lock_p1_rvalid", p1_rvalid, 1);
    chk("lock_p1_rdata", p1_rdata, 32'hA5A5_0005);
    next_cycle();
    drive_p1(1, 1, 0, 10'd5, 32'h1234_5678); mid();
    chk("lock_wr_p1_gnt", p1_gnt, 1);
    chk("lock_wr_p0_gnt", p0_gnt, 0);
    chk("lock_wr_strobe", mem_write, 1);
    next_cycle();
    drive_p1(0, 0, 0, '0, '0); drive_p0(1, 0, 0, 10'd5, '0); mid();
    chk("unlock_state", dbg_state, ARB);
    chk("unlock_p0_gnt", p0_gnt, 1);
    next_cycle();
    idle_all(); mid();
    chk("unlock_p0_rvalid", p0_rvalid, 1);
    chk("unlock_p0_rdata", p0_rdata, 32'h1234_5678);
    next_cycle();

    // Reset while p0 holds the lock with a read in flight.
    drive_p0(1, 0, 1, 10'd7, '0); mid();
    chk("rml_p0_gnt0", p0_gnt, 1);
    next_cycle();
    drive_p0(1, 0, 1, 10'd8, '0); drive_p1(1, 0, 0, 10'd9, '0); mid();
    chk("rml_state", dbg_state, LOCK0);
    chk("rml_p0_gnt1", p0_gnt, 1);
    chk("rml_p1_blocked", p1_gnt, 0);
    chk("rml_p0_rdata", p0_rdata, 32'hA5A5_0007);
    next_cycle();
    rst = 1'b1; mid();
    chk("rml_rst_p0_gnt", p0_gnt, 0);
    chk("rml_rst_p1_gnt", p1_gnt, 0);
    chk("rml_rst_mem_read", mem_read, 0);
    next_cycle();
    rst = 1'b0; drive_p0(0, 0, 0, '0, '0); mid();
    chk("rml_after_state", dbg_state, ARB);
    chk("rml_after_p1_gnt", p1_gnt, 1);
    chk("rml_after_p0_rvalid", p0_rvalid, 0);
    chk("rml_after_p1_rvalid", p1_rvalid, 0);
    next_cycle();
    idle_all(); mid();
    chk("rml_p1_rvalid", p1_rvalid, 1);
    chk("rml_p1_rdata", p1_rdata, 32'hA5A5_0009);
    chk("rml_p0_rvalid_dropped", p0_rvalid, 0);
    next_cycle();

    // Idle for ten cycles.
    for (int c = 0; c < 10; c++) begin
      mid();
      chk("idle_mem_read", mem_read, 0);
      chk("idle_mem_write", mem_write, 0);
      chk("idle_starve", dbg_starve_cnt, 0);
      chk("idle_rvalid", {p0_rvalid, p1_rvalid}, 0);
      chk("idle_rdata", {p0_rdata, p1_rdata}, 0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
